vec_packer: RTL

Bit-serial to parallel packer: accepts one bit per valid/ready handshake and writes it into an internal vector at a running index, emitting the assembled WIDTH-bit word on a valid/ready output. It is the write-side counterpart of the combinational vector-indexing/bit-select datapath: that logic reads `word[idx]`; this block builds `word` by writing `word[idx]`. It sits between a serial bit source and any consumer of packed words, such as an adder or selector.

---
 rtl/vec_pack_pkg.sv | 16 +
 rtl/vec_packer.sv | 80 ++++++++
 2 files changed

// File: rtl/vec_pack_pkg.sv
// Shared types and bit-placement helper for vec_packer.
// VEC_PACKER_MSB_FIRST_EN selects MSB-first placement; default is LSB-first.
package vec_pack_pkg;

  typedef enum logic {FILL, FULL} pack_state_t;

  // Maps the running write index to the physical bit position in the word.
  function automatic int pos(input int idx, input int width);
`ifdef VEC_PACKER_MSB_FIRST_EN
    return (idx < width) ? (width - 1 - idx) : 0;
`else
    return (idx < width) ? idx : 0;
`endif
  endfunction

endpackage

// File: rtl/vec_packer.sv
// Bit-serial to parallel packer: one bit per input handshake, WIDTH-bit word out.
// Placement order set by VEC_PACKER_MSB_FIRST_EN (see vec_pack_pkg::pos).
module vec_packer
  import vec_pack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W:0]   out_count
);

  pack_state_t      state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [IDX_W:0]   count_reg, count_next;
  logic [WIDTH-1:0] merged;
  logic             in_fire;

  assign in_ready  = (state_reg == FILL) || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_count = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      acc_reg   <= '0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      data_reg  <= data_next;
      count_reg <= count_next;
    end
  end

  // In FULL the accumulator and index are already cleared, so an input accepted
  // alongside the output handshake follows the same write path as in FILL.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    data_next  = data_reg;
    count_next = count_reg;
    merged     = acc_reg;
    merged[IDX_W'(pos(int'(idx_reg), WIDTH))] = in_bit;

    if (state_reg == FULL && out_ready) begin
      state_next = FILL;
    end

    if (in_fire) begin
      if (idx_reg == IDX_W'(WIDTH - 1) || in_flush) begin
        state_next = FULL;
        data_next  = merged;
        count_next = {1'b0, idx_reg} + (IDX_W + 1)'(1);
        idx_next   = '0;
        acc_next   = '0;
      end else begin
        acc_next = merged;
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

endmodule
